alu_cmd_frontend: RTL and testbench

Command front-end for the 4-bit combinational ALU (opcodes ADD/SUB/AND/OR/XOR/SLT). It accepts operation requests on a valid/ready interface and buffers them in a small FIFO. It issues one command per cycle to the ALU and registers the ALU's result and flags into an output stage, which also uses valid/ready. It sits directly upstream and downstream of the ALU. The ALU instance is external, and this block drives its inputs and samples its outputs.

---
 rtl/alu_cmd_frontend.sv | 122 ++++++++++++
 tb/tb_alu_cmd_frontend.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_frontend.sv
// Command front-end for the external 4-bit ALU: buffers requests in a small FIFO,
// presents the head to the ALU and registers its result into a valid/ready output stage.
module alu_cmd_frontend #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [2:0]               in_op,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_op,
    input  logic [3:0]               alu_result,
    input  logic                     alu_slt,
    input  logic                     alu_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_result,
    output logic                     out_slt,
    output logic                     out_zero,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               issued_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [3:0]    mem_a  [DEPTH];
    logic [3:0]    mem_b  [DEPTH];
    logic [2:0]    mem_op [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          out_valid_q, out_slt_q, out_zero_q, out_illegal_q;
    logic [3:0]    out_result_q;
    logic [7:0]    issued_q;

    logic          fifo_empty;
    logic          push;
    logic          issue;
    logic          head_illegal;

    assign fifo_empty   = (count_q == '0);
    // A pop in the same cycle never frees a slot for the push.
    assign in_ready     = (count_q < CW'(DEPTH)) && !flush;
    assign push         = in_valid && in_ready;
    assign issue        = !fifo_empty && (!out_valid_q || out_ready) && !flush;
    assign head_illegal = alu_op[2] && alu_op[1];

    always_comb begin
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_op = 3'd0;
        if (!fifo_empty) begin
            alu_a  = mem_a[rd_ptr_q];
            alu_b  = mem_b[rd_ptr_q];
            alu_op = mem_op[rd_ptr_q];
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q]  <= in_a;
            mem_b[wr_ptr_q]  <= in_b;
            mem_op[wr_ptr_q] <= in_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 4'd0;
            out_slt_q     <= 1'b0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            issued_q      <= 8'd0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            issued_q    <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(issue);

            if (issue) begin
                out_valid_q   <= 1'b1;
                out_illegal_q <= head_illegal;
                out_result_q  <= head_illegal ? 4'd0 : alu_result;
                out_slt_q     <= head_illegal ? 1'b0 : alu_slt;
                out_zero_q    <= head_illegal ? 1'b0 : alu_zero;
                issued_q      <= issued_q + 8'd1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_slt     = out_slt_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;
    assign count       = count_q;
    assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Self-checking bench for alu_cmd_frontend: directed and random traffic against a
// queue-based reference model, with a behavioural ALU attached to the alu_* port.
module tb_alu_cmd_frontend;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
    logic [2:0] in_op, alu_op;
    logic       alu_slt, alu_zero, out_slt, out_zero, out_illegal;
    logic [2:0] count;
    logic [7:0] issued_cnt;

    int         checks = 0;
    int         errors = 0;
    int         cyc;
    cmd_t       exp_fifo[$];
    logic       exp_ov = 1'b0;
    logic [6:0] exp_out = '0;
    logic [7:0] exp_issued = 8'd0;
    logic       last_push = 1'b0;
    logic [6:0] drained[$];

    always #5 clk = ~clk;

    alu_cmd_frontend #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_slt    (alu_slt),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_slt    (out_slt),
        .out_zero   (out_zero),
        .out_illegal(out_illegal),
        .count      (count),
        .issued_cnt (issued_cnt)
    );

    // Behavioural ALU, returns {slt, zero, result}; illegal opcodes give deliberate garbage.
    function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        logic [3:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
            default: r = 4'hA;
        endcase
        if (op > 3'd5) return {1'b1, 1'b1, r};
        return {(op == 3'd5) && r[0], r == 4'd0, r};
    endfunction

    // Expected output tuple {illegal, slt, zero, result}.
    function automatic logic [6:0] ref_out(input cmd_t c);
        if (c.op > 3'd5) return 7'h40;
        return {1'b0, alu_fn(c.a, c.b, c.op)};
    endfunction

    always_comb {alu_slt, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with inputs already applied; checks mid-cycle,
    // advances the model by one edge, and returns just after that edge.
    task automatic cycle();
        cmd_t c;
        logic can_push;
        #3;
        check("in_ready", in_ready, (exp_fifo.size() < DEPTH) && !flush);
        check("count", count, exp_fifo.size());
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) check("out_data", {out_illegal, out_slt, out_zero, out_result}, exp_out);
        check("issued_cnt", issued_cnt, exp_issued);
        if (exp_fifo.size() > 0)
            check("alu_head", {alu_a, alu_b, alu_op}, {exp_fifo[0].a, exp_fifo[0].b, exp_fifo[0].op});
        else
            check("alu_idle", {alu_a, alu_b, alu_op}, 0);
        last_push = 1'b0;
        if (flush) begin
            exp_fifo.delete();
            exp_ov     = 1'b0;
            exp_issued = 8'd0;
        end else begin
            if (out_valid && out_ready)
                drained.push_back({out_illegal, out_slt, out_zero, out_result});
            can_push = in_valid && (exp_fifo.size() < DEPTH);
            if (exp_fifo.size() > 0 && (!exp_ov || out_ready)) begin
                c          = exp_fifo.pop_front();
                exp_out    = ref_out(c);
                exp_ov     = 1'b1;
                exp_issued = exp_issued + 8'd1;
            end else if (exp_ov && out_ready) begin
                exp_ov = 1'b0;
            end
            if (can_push) begin
                c.a = in_a; c.b = in_b; c.op = in_op;
                exp_fifo.push_back(c);
                last_push = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        output int n);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_push && n < 50);
        check("send_accept", last_push, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"}, {out_valid, out_result, out_slt, out_zero, out_illegal}, 0);
        check({tag, "_cnt"}, {count, issued_cnt}, 0);
        check({tag, "_alu"}, {alu_a, alu_b, alu_op}, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0;
        #2;
        check_reset_outputs("por");
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD
        send(4'd5, 4'd3, 3'd0, cyc);
        in_valid = 1'b0;
        cycle();
        check("add_valid", out_valid, 1);
        check("add_data", {out_illegal, out_slt, out_zero, out_result}, 7'h08);
        cycle();
        check("add_done", out_valid, 0);
        idle(2);

        // Backpressure: five held, sixth refused until the consumer drains
        drained.delete();
        out_ready = 1'b0;
        send(4'd10, 4'd3, 3'd1, cyc);
        send(4'd5, 4'd5, 3'd1, cyc);
        send(4'd3, 4'd10, 3'd1, cyc);
        send(4'd0, 4'd1, 3'd1, cyc);
        send(4'd15, 4'd15, 3'd2, cyc);
        in_valid = 1'b1; in_a = 4'd0; in_b = 4'd0; in_op = 3'd3;
        repeat (3) cycle();
        check("bp_full_ready", in_ready, 0);
        check("bp_full_count", count, DEPTH);
        out_ready = 1'b1;
        send(4'd0, 4'd0, 3'd3, cyc);
        idle(8);
        check("bp_drain_n", drained.size(), 6);
        if (drained.size() == 6) begin
            check("bp_d0", drained[0], 7'h07);
            check("bp_d1", drained[1], 7'h10);
            check("bp_d2", drained[2], 7'h09);
            check("bp_d3", drained[3], 7'h0F);
            check("bp_d4", drained[4], 7'h0F);
            check("bp_d5", drained[5], 7'h10);
        end

        // Streaming with SLT corner cases
        drained.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send(4'b1001, 4'b0010, 3'd5, cyc);
            else if (i == 12) send(4'b1110, 4'b1010, 3'd5, cyc);
            else send(4'($urandom), 4'($urandom), 3'($urandom_range(0, 5)), cyc);
            check("stream_rate", cyc, 1);
        end
        idle(4);
        check("stream_n", drained.size(), 20);
        if (drained.size() == 20) begin
            check("slt_neg", drained[5], 7'h21);
            check("slt_zero", drained[12], 7'h10);
        end

        // Illegal opcode followed by XOR
        drained.delete();
        send(4'd7, 4'd1, 3'd6, cyc);
        send(4'd13, 4'd6, 3'd4, cyc);
        idle(4);
        check("ill_n", drained.size(), 2);
        if (drained.size() == 2) begin
            check("ill_first", drained[0], 7'h40);
            check("ill_xor", drained[1], 7'h0B);
        end

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            in_op     = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b1; in_valid = 1'b0;
        cycle();
        flush = 1'b0;

        // Flush with concurrent push, then counter wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'(i), 4'd1, 3'd0, cyc);
        in_valid = 1'b0;
        check("fl_pre_count", count, 3);
        check("fl_pre_valid", out_valid, 1);
        in_valid = 1'b1; in_a = 4'd9; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count", count, 0);
        check("fl_valid", out_valid, 0);
        check("fl_issued", issued_cnt, 0);
        out_ready = 1'b1;
        cycle();
        check("fl_push_dropped", {count, out_valid}, 0);
        for (int i = 0; i < 257; i++)
            send(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), cyc);
        idle(3);
        check("wrap_issued", issued_cnt, 1);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd2, 4'(i), 3'd1, cyc);
        in_valid = 1'b0;
        check("rst_pre", {count, out_valid}, {3'd3, 1'b1});
        #2; rst_n = 1'b0; #1;
        check_reset_outputs("async_rst");
        exp_fifo.delete(); exp_ov = 1'b0; exp_issued = 8'd0;
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);
        check("rst_no_stale", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
